// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM states, owner encoding and
// default widths. Arbitration policy macro: YSYX_23060251_ARB_RR_EN.
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 64;
    localparam int DATA_W_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // One-hot grant vector: bit 0 = IFU, bit 1 = LSU.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IFU  = 2'b01;
    localparam logic [1:0] GNT_LSU  = 2'b10;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between IFU and LSU while the arbiter is idle.
// YSYX_23060251_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic       i_if_valid,
    input  logic       i_ls_valid,
    input  logic       i_last_owner,
    input  logic       i_idle,
    output logic [1:0] o_grant
);

`ifndef YSYX_23060251_ARB_RR_EN
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;
`endif

    always_comb begin
        o_grant = GNT_NONE;
        if (i_idle) begin
            if (i_if_valid && i_ls_valid) begin
`ifdef YSYX_23060251_ARB_RR_EN
                // On contention, favour whoever did not win last time.
                o_grant = (i_last_owner == OWN_LSU) ? GNT_IFU : GNT_LSU;
`else
                o_grant = GNT_LSU;
`endif
            end else if (i_ls_valid) begin
                o_grant = GNT_LSU;
            end else if (i_if_valid) begin
                o_grant = GNT_IFU;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-requester (IFU/LSU) memory arbiter, one transaction in flight at a time.
// Policy macro YSYX_23060251_ARB_RR_EN: defined = round-robin, undefined = LSU priority.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  if_req_valid_i,
    output logic                  if_req_ready_o,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_resp_valid_o,

    input  logic                  ls_req_valid_i,
    output logic                  ls_req_ready_o,
    input  logic [ADDR_W-1:0]     ls_addr_i,
    input  logic                  ls_wen_i,
    input  logic [DATA_W-1:0]     ls_wdata_i,
    input  logic [DATA_W/8-1:0]   ls_mask_i,
    output logic                  ls_resp_valid_o,

    output logic [DATA_W-1:0]     rdata_o,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_wen_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_mask_o,

    input  logic                  mem_resp_valid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    arb_state_e r_state;
    owner_e     r_owner;

    logic       w_idle;
    logic [1:0] w_grant;
    logic       w_if_fire;
    logic       w_ls_fire;

    assign w_idle = (r_state == ST_IDLE);

    mem_arb_grant u_grant (
        .i_if_valid   (if_req_valid_i),
        .i_ls_valid   (ls_req_valid_i),
        .i_last_owner (r_owner),
        .i_idle       (w_idle),
        .o_grant      (w_grant)
    );

    // The state register is already IDLE during reset, so ready is also gated
    // by reset to keep both requesters stalled until it is released.
    assign if_req_ready_o = w_grant[0] & rst_n_i;
    assign ls_req_ready_o = w_grant[1] & rst_n_i;

    assign w_if_fire = if_req_valid_i & if_req_ready_o;
    assign w_ls_fire = ls_req_valid_i & ls_req_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state         <= ST_IDLE;
            r_owner         <= OWN_IFU;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_wen_o       <= 1'b0;
            mem_wdata_o     <= '0;
            mem_mask_o      <= '0;
            rdata_o         <= '0;
            if_resp_valid_o <= 1'b0;
            ls_resp_valid_o <= 1'b0;
        end else begin
            if_resp_valid_o <= 1'b0;
            ls_resp_valid_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ls_fire) begin
                        mem_addr_o      <= ls_addr_i;
                        mem_wen_o       <= ls_wen_i;
                        mem_wdata_o     <= ls_wdata_i;
                        mem_mask_o      <= ls_mask_i;
                        r_owner         <= OWN_LSU;
                        mem_req_valid_o <= 1'b1;
                        r_state         <= ST_REQ;
                    end else if (w_if_fire) begin
                        // Instruction fetches are always full-width reads.
                        mem_addr_o      <= if_addr_i;
                        mem_wen_o       <= 1'b0;
                        mem_wdata_o     <= '0;
                        mem_mask_o      <= '1;
                        r_owner         <= OWN_IFU;
                        mem_req_valid_o <= 1'b1;
                        r_state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        r_state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid_i) begin
                        rdata_o <= mem_rdata_i;
                        if (r_owner == OWN_LSU) begin
                            ls_resp_valid_o <= 1'b1;
                        end else begin
                            if_resp_valid_o <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios followed by random traffic,
// scored against a transaction-level model of the arbitration rules.
module tb_mem_arb;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;

`ifdef YSYX_23060251_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b1;
    logic          if_req_valid_i = 1'b0;
    logic          if_req_ready_o;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_resp_valid_o;
    logic          ls_req_valid_i = 1'b0;
    logic          ls_req_ready_o;
    logic [AW-1:0] ls_addr_i = '0;
    logic          ls_wen_i = 1'b0;
    logic [DW-1:0] ls_wdata_i = '0;
    logic [MW-1:0] ls_mask_i = '0;
    logic          ls_resp_valid_o;
    logic [DW-1:0] rdata_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i = 1'b0;
    logic [AW-1:0] mem_addr_o;
    logic          mem_wen_o;
    logic [DW-1:0] mem_wdata_o;
    logic [MW-1:0] mem_mask_o;
    logic          mem_resp_valid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .if_req_valid_i   (if_req_valid_i),
        .if_req_ready_o   (if_req_ready_o),
        .if_addr_i        (if_addr_i),
        .if_resp_valid_o  (if_resp_valid_o),
        .ls_req_valid_i   (ls_req_valid_i),
        .ls_req_ready_o   (ls_req_ready_o),
        .ls_addr_i        (ls_addr_i),
        .ls_wen_i         (ls_wen_i),
        .ls_wdata_i       (ls_wdata_i),
        .ls_mask_i        (ls_mask_i),
        .ls_resp_valid_o  (ls_resp_valid_o),
        .rdata_o          (rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_wen_o        (mem_wen_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_mask_o       (mem_mask_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", tag, act, exp);
        end
    endtask

    // Reference model: the transaction in flight and what the requesters should see.
    bit            busy;
    bit            sent;
    bit            last_lsu;
    bit            cur_lsu;
    logic [AW-1:0] cur_addr;
    bit            cur_wen;
    logic [DW-1:0] cur_wdata;
    logic [MW-1:0] cur_mask;
    bit            exp_if_pulse;
    bit            exp_ls_pulse;
    logic [DW-1:0] exp_rdata;
    int            if_pulses;
    int            ls_pulses;
    bit            grant_log[$];

    task automatic model_reset();
        busy = 1'b0;
        sent = 1'b0;
        last_lsu = 1'b0;
        exp_if_pulse = 1'b0;
        exp_ls_pulse = 1'b0;
    endtask

    // One clock cycle: check at the falling edge, advance the model for the
    // coming rising edge, then retire accepted requests just after it.
    task automatic step();
        bit g_if, g_ls, acc_if, acc_ls;
        @(negedge clk_i);
        g_if = 1'b0;
        g_ls = 1'b0;
        if (!busy) begin
            if (if_req_valid_i && ls_req_valid_i) begin
                g_ls = RR ? !last_lsu : 1'b1;
                g_if = !g_ls;
            end else begin
                g_ls = ls_req_valid_i;
                g_if = if_req_valid_i;
            end
        end
        check("if_ready", if_req_ready_o, g_if);
        check("ls_ready", ls_req_ready_o, g_ls);
        check("mem_valid", mem_req_valid_o, busy && !sent);
        if (busy && !sent) begin
            check("mem_addr", mem_addr_o, cur_addr);
            check("mem_wen", mem_wen_o, cur_wen);
            check("mem_mask", mem_mask_o, cur_mask);
            if (cur_lsu) check("mem_wdata", mem_wdata_o, cur_wdata);
        end
        check("if_resp", if_resp_valid_o, exp_if_pulse);
        check("ls_resp", ls_resp_valid_o, exp_ls_pulse);
        if (exp_if_pulse || exp_ls_pulse) begin
            check("rdata", rdata_o, exp_rdata);
            $display("txn %s addr=%h wen=%0d rdata=%h", cur_lsu ? "LSU" : "IFU",
                     cur_addr, cur_wen, rdata_o);
        end
        if (if_resp_valid_o) if_pulses++;
        if (ls_resp_valid_o) ls_pulses++;

        acc_if = if_req_valid_i && if_req_ready_o;
        acc_ls = ls_req_valid_i && ls_req_ready_o;
        if (acc_ls) grant_log.push_back(1'b1);
        else if (acc_if) grant_log.push_back(1'b0);

        exp_if_pulse = 1'b0;
        exp_ls_pulse = 1'b0;
        if (!busy) begin
            if (g_ls || g_if) begin
                busy = 1'b1;
                sent = 1'b0;
                cur_lsu = g_ls;
                last_lsu = g_ls;
                cur_addr = g_ls ? ls_addr_i : if_addr_i;
                cur_wen = g_ls ? ls_wen_i : 1'b0;
                cur_wdata = ls_wdata_i;
                cur_mask = g_ls ? ls_mask_i : {MW{1'b1}};
            end
        end else if (!sent) begin
            if (mem_req_ready_i) sent = 1'b1;
        end else if (mem_resp_valid_i) begin
            exp_rdata = mem_rdata_i;
            exp_ls_pulse = cur_lsu;
            exp_if_pulse = !cur_lsu;
            busy = 1'b0;
        end

        @(posedge clk_i);
        #1;
        if (acc_if) if_req_valid_i = 1'b0;
        if (acc_ls) ls_req_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        if_req_valid_i = 1'b1;
        ls_req_valid_i = 1'b1;
        #1;
        check("rst_if_ready", if_req_ready_o, 1'b0);
        check("rst_ls_ready", ls_req_ready_o, 1'b0);
        check("rst_mem_valid", mem_req_valid_o, 1'b0);
        check("rst_mem_wen", mem_wen_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 64'h0);
        check("rst_mem_wdata", mem_wdata_o, 64'h0);
        check("rst_mem_mask", mem_mask_o, 64'h0);
        check("rst_rdata", rdata_o, 64'h0);
        check("rst_if_resp", if_resp_valid_o, 1'b0);
        check("rst_ls_resp", ls_resp_valid_o, 1'b0);
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        mem_req_ready_i = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = {$urandom, $urandom};
        for (int k = 0; k < 20 && (busy || exp_if_pulse || exp_ls_pulse); k++) step();
        check("drain_done", busy || exp_if_pulse || exp_ls_pulse, 1'b0);
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
    endtask

    bit exp_c[2];
    bit exp_d[4];

    initial begin
        model_reset();
        #2;
        do_reset();

        // IFU read with an immediately ready memory.
        if_pulses = 0;
        ls_pulses = 0;
        if_addr_i = 64'h8000_0000;
        if_req_valid_i = 1'b1;
        mem_req_ready_i = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = 64'h1122334455667788;
        for (int k = 0; k < 12 && if_pulses == 0; k++) step();
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        step();
        check("A_if_pulses", if_pulses, 1);
        check("A_ls_pulses", ls_pulses, 0);
        check("A_rdata", rdata_o, 64'h1122334455667788);

        // LSU byte store held against a stalled memory for three cycles.
        if_pulses = 0;
        ls_pulses = 0;
        ls_addr_i = 64'h8000_0010;
        ls_wen_i = 1'b1;
        ls_wdata_i = 64'hAB;
        ls_mask_i = 8'h01;
        ls_req_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("B_valid_held", mem_req_valid_o, 1'b1);
            check("B_wen_held", mem_wen_o, 1'b1);
            check("B_mask_held", mem_mask_o, 64'h01);
            check("B_addr_held", mem_addr_o, 64'h8000_0010);
        end
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = 64'h0;
        for (int k = 0; k < 10 && ls_pulses == 0; k++) step();
        mem_resp_valid_i = 1'b0;
        step();
        check("B_ls_pulses", ls_pulses, 1);
        check("B_if_pulses", if_pulses, 0);

        // Contention from idle, last grant was the LSU.
        exp_c[0] = RR ? 1'b0 : 1'b1;
        exp_c[1] = RR ? 1'b1 : 1'b0;
        grant_log.delete();
        if_pulses = 0;
        ls_pulses = 0;
        if_addr_i = 64'h8000_0100;
        ls_addr_i = 64'h8000_0200;
        ls_wen_i = 1'b0;
        ls_mask_i = 8'hFF;
        if_req_valid_i = 1'b1;
        ls_req_valid_i = 1'b1;
        mem_req_ready_i = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = 64'hC0FFEE;
        for (int k = 0; k < 20 && (if_pulses + ls_pulses) < 2; k++) step();
        check("C_grants", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("C_first", grant_log[0], exp_c[0]);
            check("C_second", grant_log[1], exp_c[1]);
        end
        drain();

        // Both requesters continuously valid for four transactions.
        for (int i = 0; i < 4; i++) exp_d[i] = RR ? i[0] : 1'b1;
        grant_log.delete();
        mem_req_ready_i = 1'b1;
        mem_resp_valid_i = 1'b1;
        for (int k = 0; k < 60 && grant_log.size() < 4; k++) begin
            if (!if_req_valid_i) begin
                if_req_valid_i = 1'b1;
                if_addr_i = {$urandom, $urandom};
            end
            if (!ls_req_valid_i) begin
                ls_req_valid_i = 1'b1;
                ls_addr_i = {$urandom, $urandom};
            end
            mem_rdata_i = {$urandom, $urandom};
            step();
        end
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        check("D_grants", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("D_grant%0d", i), grant_log[i], exp_d[i]);
        end
        drain();

        // Reset while waiting for the memory response abandons the transaction.
        if_addr_i = 64'h8000_0400;
        if_req_valid_i = 1'b1;
        mem_req_ready_i = 1'b1;
        for (int k = 0; k < 10 && !(busy && sent); k++) step();
        check("E_in_resp", busy && sent, 1'b1);
        #2;
        do_reset();
        if_pulses = 0;
        ls_pulses = 0;
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = 64'hDEAD_BEEF;
        repeat (5) step();
        mem_resp_valid_i = 1'b0;
        check("E_if_pulses", if_pulses, 0);
        check("E_ls_pulses", ls_pulses, 0);
        check("E_mem_valid", mem_req_valid_o, 1'b0);
        if_req_valid_i = 1'b1;
        #1;
        check("E_idle_ready", if_req_ready_o, 1'b1);
        drain();

        // Random traffic with random memory stalls and stray responses.
        for (int c = 0; c < 3000; c++) begin
            if (!if_req_valid_i && $urandom_range(0, 2) == 0) begin
                if_req_valid_i = 1'b1;
                if_addr_i = {$urandom, $urandom};
            end
            if (!ls_req_valid_i && $urandom_range(0, 2) == 0) begin
                ls_req_valid_i = 1'b1;
                ls_addr_i = {$urandom, $urandom};
                ls_wen_i = $urandom_range(0, 1) == 1;
                ls_wdata_i = {$urandom, $urandom};
                ls_mask_i = 8'($urandom);
            end
            mem_req_ready_i = $urandom_range(0, 2) != 0;
            mem_resp_valid_i = $urandom_range(0, 2) == 0;
            mem_rdata_i = {$urandom, $urandom};
            step();
        end
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, default 64, sets the byte-address width.
REQ-002 Parameter DATA_W, default 64, sets the data width; the mask width SHALL be DATA_W/8.
REQ-003 Port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 IFU request port SHALL be: if_req_valid_i in 1; if_req_ready_o out 1; if_addr_i in ADDR_W.
REQ-006 IFU response port SHALL be if_resp_valid_o, out, 1 bit: read-data pulse for the IFU.
REQ-007 LSU request port SHALL be: ls_req_valid_i in 1; ls_req_ready_o out 1; ls_addr_i in ADDR_W; ls_wen_i in 1 (1 = store); ls_wdata_i in DATA_W; ls_mask_i in DATA_W/8.
REQ-008 LSU response port SHALL be ls_resp_valid_o, out, 1 bit: load-data or store-ack pulse.
REQ-009 Port rdata_o, out, DATA_W: registered read data, shared by both requesters.
REQ-010 Memory request port SHALL be: mem_req_valid_o out 1; mem_req_ready_i in 1; mem_addr_o out ADDR_W; mem_wen_o out 1; mem_wdata_o out DATA_W; mem_mask_o out DATA_W/8.
REQ-011 Memory response port SHALL be: mem_resp_valid_i in 1; mem_rdata_i in DATA_W.

Function
REQ-012 The block SHALL implement FSM states IDLE, REQ and RESP, one transaction outstanding at most.
REQ-013 In IDLE, ready SHALL be driven combinationally to exactly one valid requester (the grant); no ready is driven in REQ or RESP.
REQ-014 Handshake: a request is accepted when valid and ready are both 1; the accepted address, wen, wdata, mask and owner SHALL be latched; IDLE->REQ.
REQ-015 In REQ, mem_req_valid_o=1 with the latched fields stable; on mem_req_ready_i=1, REQ->RESP. Minimum delay from acceptance to mem_req_valid_o is 1 cycle.
REQ-016 In RESP, on mem_resp_valid_i=1, rdata_o<=mem_rdata_i and the owner's resp_valid SHALL pulse for exactly 1 cycle on the next cycle; RESP->IDLE.
REQ-017 A new grant SHALL be possible in the same cycle the resp pulse is high.
REQ-018 For an IFU transaction mem_wen_o=0 and mem_mask_o=all ones; for an LSU transaction the LSU fields pass through unchanged.
REQ-019 Both valid in IDLE SHALL grant per REQ-030/031; the loser's valid is held and is not dropped.
REQ-020 mem_resp_valid_i outside RESP SHALL be ignored.
REQ-021 Addresses SHALL NOT be checked for alignment.
REQ-022 When idle, mem_req_valid_o=0 and both resp_valid outputs are 0.

Reset
REQ-023 Asserting rst_n_i low SHALL force IDLE, and zero all of the following: mem_req_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_mask_o, rdata_o, if_resp_valid_o, ls_resp_valid_o. The owner/last-grant register SHALL be set to IFU.
REQ-024 Reset mid-transaction SHALL abandon the transaction; no resp pulse SHALL follow.
REQ-025 Ready outputs SHALL be 0 while rst_n_i is low.

Configuration
REQ-026 Macro YSYX_23060251_ARB_RR_EN selects the arbitration policy.
REQ-027 With YSYX_23060251_ARB_RR_EN undefined, fixed priority SHALL apply: LSU over IFU.
REQ-028 With YSYX_23060251_ARB_RR_EN defined, round-robin SHALL apply: on contention, grant the requester not granted last.
REQ-029 The macro SHALL affect the grant only; timing is identical with or without it.
REQ-030 Fixed-priority contention -> LSU.
REQ-031 Round-robin contention -> the alternate of the last grant.

Structure
REQ-032 The shared defines header SHALL carry the FSM state encodings, the ADDR_W/DATA_W defaults, and the owner encoding (IFU=0, LSU=1).
REQ-033 Grant logic SHALL be one sub-module, mem_arb_grant: inputs are both valids, last owner and idle; the output is a one-hot grant.

Verification
REQ-034 IFU read 0x8000_0000, mem_req_ready_i=1 at once, rdata 0x1122334455667788 one cycle later -> if_resp_valid_o pulses 1 cycle with rdata_o=0x1122334455667788; ls_resp_valid_o stays 0.
REQ-035 LSU store 0x8000_0010, wdata 0xAB, mask 0x01 -> mem_wen_o=1, mem_mask_o=0x01 and the fields are held 3 cycles while mem_req_ready_i=0; ls_resp_valid_o pulses after the ack.
REQ-036 Both valid in IDLE, macro off -> LSU granted; IFU granted after the LSU response.
REQ-037 Macro on, both valid continuously for 4 transactions -> grants alternate IFU, LSU, IFU, LSU.
REQ-038 rst_n_i low while in RESP, then mem_resp_valid_i=1 after release -> no resp pulse; state is IDLE.
